// File: rtl/quadrature_nco.sv
// Quadrature NCO: phase accumulator with handshaked frequency load, phase offset
// and sync, driving a quarter-wave sine ROM through a 3-stage registered pipeline.
module quadrature_nco #(
  parameter int DATA_WIDTH  = 12,
  parameter int LUT_DEPTH   = 10,
  parameter int PHASE_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          sample_clk_ce,
  input  logic [PHASE_WIDTH-1:0]        freq_word,
  input  logic                          freq_valid,
  output logic                          freq_ready,
  input  logic [PHASE_WIDTH-1:0]        phase_offset,
  input  logic                          phase_sync,
  output logic signed [DATA_WIDTH-1:0]  sinewave,
  output logic signed [DATA_WIDTH-1:0]  cosinewave,
  output logic                          out_valid
);

  localparam int     N     = 2 ** (LUT_DEPTH - 2);
  localparam int     IDX_W = LUT_DEPTH - 2;
  localparam int     MAG_W = DATA_WIDTH - 1;
  localparam longint AMP   = (longint'(1) <<< (DATA_WIDTH - 1)) - 1;

  // round(AMP * sin(pi/2 * k/N)) via a Q30 integer Taylor series.
  function automatic longint quarter_sine(input int k);
    longint x, term, sum;
    x    = (64'sd1686629713 * longint'(k)) / longint'(N);
    term = x;
    sum  = x;
    for (int i = 1; i <= 10; i++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = -term / longint'((2 * i) * (2 * i + 1));
      sum += term;
    end
    return (sum * AMP + (longint'(1) <<< 29)) >>> 30;
  endfunction

  logic [MAG_W-1:0] quarter_rom [N+1];

  for (genvar k = 0; k <= N; k++) begin : g_rom
    localparam longint VAL = quarter_sine(k);
    assign quarter_rom[k] = MAG_W'(VAL);
  end

  // Returns {negate, magnitude} for one full-cycle table address.
  function automatic logic [MAG_W:0] lookup(input logic [LUT_DEPTH-1:0] addr);
    logic [1:0]       q;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   ridx;
    q    = addr[LUT_DEPTH-1 -: 2];
    idx  = addr[IDX_W-1:0];
    ridx = (IDX_W + 1)'(N) - {1'b0, idx};
    return {q[1], q[0] ? quarter_rom[ridx] : quarter_rom[{1'b0, idx}]};
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] signed_sample(
    input logic             neg,
    input logic [MAG_W-1:0] mag
  );
    logic signed [DATA_WIDTH-1:0] m;
    m = signed'({1'b0, mag});
    return neg ? -m : m;
  endfunction

  logic [PHASE_WIDTH-1:0] acc, inc_active, shadow;
  logic                   pending, sync_pending;
  logic [PHASE_WIDTH-1:0] step;
  logic                   accept, sync_now;
  logic [LUT_DEPTH-1:0]   a_next;
  logic [PHASE_WIDTH-LUT_DEPTH-1:0] unused_phase_frac;

  assign freq_ready = !pending;
  assign accept     = freq_valid && !pending;
  assign sync_now   = phase_sync || sync_pending;
  // A word still pending at a ce is used by that very ce.
  assign step       = pending ? shadow : inc_active;
  assign {a_next, unused_phase_frac} = acc + phase_offset;

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      acc          <= '0;
      inc_active   <= '0;
      shadow       <= '0;
      pending      <= 1'b0;
      sync_pending <= 1'b0;
    end else begin
      if (sample_clk_ce) begin
        acc          <= sync_now ? '0 : acc + step;
        sync_pending <= 1'b0;
        if (pending) begin
          inc_active <= shadow;
          pending    <= 1'b0;
        end
      end else if (phase_sync) begin
        sync_pending <= 1'b1;
      end
      if (accept) begin
        shadow  <= freq_word;
        pending <= 1'b1;
      end
    end
  end

  logic [LUT_DEPTH-1:0] sin_addr, cos_addr;
  logic [MAG_W-1:0]     sin_mag, cos_mag;
  logic                 sin_neg, cos_neg;
  logic                 v1, v2;

  // NOTE: every pipeline register is reset so an in-flight sample can never strobe out
  // after arst; the ROM is a constant and needs no reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      out_valid  <= 1'b0;
      sin_addr   <= '0;
      cos_addr   <= '0;
      sin_mag    <= '0;
      cos_mag    <= '0;
      sin_neg    <= 1'b0;
      cos_neg    <= 1'b0;
      sinewave   <= '0;
      cosinewave <= '0;
    end else begin
      v1        <= sample_clk_ce;
      v2        <= v1;
      out_valid <= v2;
      if (sample_clk_ce) begin
        sin_addr <= a_next;
        cos_addr <= a_next + LUT_DEPTH'(N);
      end
      if (v1) begin
        {sin_neg, sin_mag} <= lookup(sin_addr);
        {cos_neg, cos_mag} <= lookup(cos_addr);
      end
      if (v2) begin
        sinewave   <= signed_sample(sin_neg, sin_mag);
        cosinewave <= signed_sample(cos_neg, cos_mag);
      end
    end
  end

endmodule

// File: tb/tb_quadrature_nco.sv
// Self-checking bench for quadrature_nco: directed scenarios plus random traffic
// against a cycle-level model of the accumulator rules and real-valued sin/cos.
module tb_quadrature_nco;

  localparam int DW = 12;
  localparam int LD = 10;
  localparam int PW = 32;
  localparam real PI = 3.141592653589793;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  logic ce   = 1'b0;
  logic fv   = 1'b0;
  logic ps   = 1'b0;
  logic [PW-1:0] fw = '0;
  logic [PW-1:0] po = '0;
  logic freq_ready, out_valid;
  logic signed [DW-1:0] sinewave, cosinewave;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct { int s; int c; int t; } samp_t;
  samp_t exp_q[$];
  samp_t obs_q[$];

  logic [PW-1:0] m_acc = '0, m_inc = '0, m_shadow = '0;
  bit m_pend = 1'b0, m_sync = 1'b0;

  always #5 clk = ~clk;

  quadrature_nco #(.DATA_WIDTH(DW), .LUT_DEPTH(LD), .PHASE_WIDTH(PW)) dut (
    .clk          (clk),
    .arst         (arst),
    .sample_clk_ce(ce),
    .freq_word    (fw),
    .freq_valid   (fv),
    .freq_ready   (freq_ready),
    .phase_offset (po),
    .phase_sync   (ps),
    .sinewave     (sinewave),
    .cosinewave   (cosinewave),
    .out_valid    (out_valid)
  );

  // Ideal sample for the top LD phase bits, rounded half away from zero.
  function automatic int ref_wave(input logic [PW-1:0] ph, input bit cosine);
    logic [LD-1:0] a;
    real ang, v;
    a   = ph[PW-1 -: LD];
    ang = 2.0 * PI * real'(a) / 1024.0;
    v   = 2047.0 * (cosine ? $cos(ang) : $sin(ang));
    return (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
  endfunction

  always @(posedge clk or posedge arst) begin : model
    logic [PW-1:0] ph, stp;
    bit take;
    if (arst) begin
      m_acc = '0; m_inc = '0; m_shadow = '0; m_pend = 1'b0; m_sync = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      take = fv && !m_pend;
      if (ce) begin
        ph = m_acc + po;
        exp_q.push_back('{ref_wave(ph, 1'b0), ref_wave(ph, 1'b1), cyc + 2});
        stp = m_pend ? m_shadow : m_inc;
        if (m_pend) begin
          m_inc  = m_shadow;
          m_pend = 1'b0;
        end
        m_acc  = (ps || m_sync) ? '0 : m_acc + stp;
        m_sync = 1'b0;
      end else if (ps) begin
        m_sync = 1'b1;
      end
      if (take) begin
        m_shadow = fw;
        m_pend   = 1'b1;
      end
    end
  end

  always @(negedge clk)
    if (out_valid) obs_q.push_back('{int'($signed(sinewave)), int'($signed(cosinewave)), cyc});

  task automatic tick(input bit c, input bit v, input logic [PW-1:0] w, input bit s);
    @(negedge clk);
    ce = c; fv = v; fw = w; ps = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic pull(output samp_t o, output samp_t e, output bit have);
    o    = obs_q.pop_front();
    have = exp_q.size() > 0;
    if (have) e = exp_q.pop_front();
    else      e = '{0, 0, -1};
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (sinewave !== 12'sd0) begin n_fail++; $display("FAIL reset_sin: got %0d want 0", sinewave); end
    n_checks++;
    if (cosinewave !== 12'sd0) begin n_fail++; $display("FAIL reset_cos: got %0d want 0", cosinewave); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++;
    if (freq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", freq_ready); end
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic test_startup();
    int want_s[8] = '{0, 0, 2047, 0, -2047, 0, 2047, 0};
    int want_c[8] = '{2047, 2047, 0, -2047, 0, 2047, 0, -2047};
    samp_t o, e;
    bit have;
    int i = 0;
    po = '0;
    tick(1'b1, 1'b1, 32'h4000_0000, 1'b0);
    repeat (7) tick(1'b1, 1'b0, '0, 1'b0);
    idle(4);
    #1;
    while (obs_q.size() > 0) begin
      pull(o, e, have);
      n_checks++;
      if (!have || o.s !== e.s || o.c !== e.c || o.t !== e.t) begin
        n_fail++;
        $display("FAIL startup_model[%0d]: got sin %0d cos %0d cyc %0d, want sin %0d cos %0d cyc %0d", i, o.s, o.c, o.t, e.s, e.c, e.t);
      end
      if (i < 8) begin
        n_checks++;
        if (o.s !== want_s[i] || o.c !== want_c[i]) begin
          n_fail++;
          $display("FAIL startup_seq[%0d]: got sin %0d cos %0d, want sin %0d cos %0d", i, o.s, o.c, want_s[i], want_c[i]);
        end
      end
      i++;
    end
    n_checks++;
    if (i != 8 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL startup_count: got %0d samples (%0d unmatched), want 8", i, exp_q.size());
    end
  endtask

  task automatic test_handshake();
    logic [PW-1:0] want_ph[4] = '{32'h0000_0000, 32'h0100_0000, 32'h0300_0000, 32'h0500_0000};
    samp_t o, e;
    bit have;
    int i = 0;
    tick(1'b1, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b1, 32'h0100_0000, 1'b0);
    tick(1'b0, 1'b1, 32'h0200_0000, 1'b0);
    #1;
    n_checks++;
    if (freq_ready !== 1'b0) begin n_fail++; $display("FAIL hs_ready_busy: got %b want 0", freq_ready); end
    tick(1'b0, 1'b1, 32'h0200_0000, 1'b0);
    tick(1'b1, 1'b1, 32'h0200_0000, 1'b0);
    tick(1'b0, 1'b1, 32'h0200_0000, 1'b0);
    #1;
    n_checks++;
    if (freq_ready !== 1'b1) begin n_fail++; $display("FAIL hs_ready_free: got %b want 1", freq_ready); end
    repeat (3) tick(1'b1, 1'b0, '0, 1'b0);
    idle(4);
    #1;
    while (obs_q.size() > 0) begin
      pull(o, e, have);
      n_checks++;
      if (!have || o.s !== e.s || o.c !== e.c || o.t !== e.t) begin
        n_fail++;
        $display("FAIL hs_model[%0d]: got sin %0d cos %0d cyc %0d, want sin %0d cos %0d cyc %0d", i, o.s, o.c, o.t, e.s, e.c, e.t);
      end
      if (i >= 1 && i <= 4) begin
        n_checks++;
        if (o.s !== ref_wave(want_ph[i-1], 1'b0) || o.c !== ref_wave(want_ph[i-1], 1'b1)) begin
          n_fail++;
          $display("FAIL hs_step[%0d]: got sin %0d cos %0d, want phase %h", i, o.s, o.c, want_ph[i-1]);
        end
      end
      i++;
    end
    n_checks++;
    if (i != 5 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL hs_count: got %0d samples (%0d unmatched), want 5", i, exp_q.size());
    end
  endtask

  task automatic test_offset();
    samp_t o, e;
    bit have;
    int i = 0;
    po = 32'h2000_0000;
    tick(1'b0, 1'b1, '0, 1'b1);
    repeat (6) tick(1'b1, 1'b0, '0, 1'b0);
    idle(4);
    #1;
    while (obs_q.size() > 0) begin
      pull(o, e, have);
      n_checks++;
      if (!have || o.s !== e.s || o.c !== e.c || o.t !== e.t) begin
        n_fail++;
        $display("FAIL offset_model[%0d]: got sin %0d cos %0d cyc %0d, want sin %0d cos %0d cyc %0d", i, o.s, o.c, o.t, e.s, e.c, e.t);
      end
      if (i >= 1) begin
        n_checks++;
        if (o.s !== 1447 || o.c !== 1447) begin
          n_fail++;
          $display("FAIL offset_value[%0d]: got sin %0d cos %0d, want 1447 1447", i, o.s, o.c);
        end
      end
      i++;
    end
    n_checks++;
    if (i != 6 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL offset_count: got %0d samples (%0d unmatched), want 6", i, exp_q.size());
    end
    po = '0;
  endtask

  task automatic test_phase_sync();
    samp_t o, e;
    bit have;
    int i = 0;
    tick(1'b0, 1'b1, 32'h4000_0000, 1'b1);
    repeat (4) tick(1'b1, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1);
    repeat (3) tick(1'b1, 1'b0, '0, 1'b0);
    idle(4);
    #1;
    while (obs_q.size() > 0) begin
      pull(o, e, have);
      n_checks++;
      if (!have || o.s !== e.s || o.c !== e.c || o.t !== e.t) begin
        n_fail++;
        $display("FAIL sync_model[%0d]: got sin %0d cos %0d cyc %0d, want sin %0d cos %0d cyc %0d", i, o.s, o.c, o.t, e.s, e.c, e.t);
      end
      if (i == 4) begin
        n_checks++;
        if (o.s !== -2047 || o.c !== 0) begin
          n_fail++;
          $display("FAIL sync_old_phase: got sin %0d cos %0d, want -2047 0", o.s, o.c);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (o.s !== 0 || o.c !== 2047) begin
          n_fail++;
          $display("FAIL sync_cleared: got sin %0d cos %0d, want 0 2047", o.s, o.c);
        end
      end
      i++;
    end
    n_checks++;
    if (i != 7 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sync_count: got %0d samples (%0d unmatched), want 7", i, exp_q.size());
    end
  endtask

  task automatic test_negative_freq();
    int want_s[4] = '{0, -2047, 0, 2047};
    int want_c[4] = '{2047, 0, -2047, 0};
    samp_t o, e;
    bit have;
    int i = 0;
    tick(1'b0, 1'b1, 32'hC000_0000, 1'b1);
    repeat (5) tick(1'b1, 1'b0, '0, 1'b0);
    idle(4);
    #1;
    while (obs_q.size() > 0) begin
      pull(o, e, have);
      n_checks++;
      if (!have || o.s !== e.s || o.c !== e.c || o.t !== e.t) begin
        n_fail++;
        $display("FAIL negf_model[%0d]: got sin %0d cos %0d cyc %0d, want sin %0d cos %0d cyc %0d", i, o.s, o.c, o.t, e.s, e.c, e.t);
      end
      if (i >= 1 && i <= 4) begin
        n_checks++;
        if (o.s !== want_s[i-1] || o.c !== want_c[i-1]) begin
          n_fail++;
          $display("FAIL negf_seq[%0d]: got sin %0d cos %0d, want sin %0d cos %0d", i, o.s, o.c, want_s[i-1], want_c[i-1]);
        end
      end
      i++;
    end
    n_checks++;
    if (i != 5 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL negf_count: got %0d samples (%0d unmatched), want 5", i, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    samp_t o, e;
    bit have;
    int i = 0;
    for (int k = 0; k < 400; k++) begin
      po = $urandom();
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom(), $urandom_range(0, 15) == 0);
    end
    po = '0;
    idle(4);
    #1;
    while (obs_q.size() > 0) begin
      pull(o, e, have);
      n_checks++;
      if (!have || o.s !== e.s || o.c !== e.c || o.t !== e.t) begin
        n_fail++;
        $display("FAIL random_model[%0d]: got sin %0d cos %0d cyc %0d, want sin %0d cos %0d cyc %0d", i, o.s, o.c, o.t, e.s, e.c, e.t);
      end
      i++;
    end
    n_checks++;
    if (exp_q.size() != 0 || i == 0) begin
      n_fail++;
      $display("FAIL random_count: got %0d samples, %0d expected ones missing", i, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    samp_t o, e;
    bit have;
    int i = 0;
    tick(1'b1, 1'b1, 32'h1234_5678, 1'b0);
    @(posedge clk);
    #2;
    arst = 1'b1;
    #1;
    n_checks++;
    if (sinewave !== 12'sd0 || cosinewave !== 12'sd0) begin
      n_fail++;
      $display("FAIL arst_outputs: got sin %0d cos %0d, want 0 0", sinewave, cosinewave);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", out_valid); end
    n_checks++;
    if (freq_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b want 1", freq_ready); end
    tick(1'b0, 1'b0, '0, 1'b0);
    idle(3);
    arst = 1'b0;
    repeat (2) tick(1'b1, 1'b0, '0, 1'b0);
    idle(4);
    #1;
    while (obs_q.size() > 0) begin
      pull(o, e, have);
      n_checks++;
      if (!have || o.s !== e.s || o.c !== e.c || o.t !== e.t) begin
        n_fail++;
        $display("FAIL arst_model[%0d]: got sin %0d cos %0d cyc %0d, want sin %0d cos %0d cyc %0d", i, o.s, o.c, o.t, e.s, e.c, e.t);
      end
      n_checks++;
      if (o.s !== 0 || o.c !== 2047) begin
        n_fail++;
        $display("FAIL arst_first[%0d]: got sin %0d cos %0d, want 0 2047", i, o.s, o.c);
      end
      i++;
    end
    n_checks++;
    if (i != 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL arst_count: got %0d samples (%0d unmatched), want 2", i, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_handshake();
    test_offset();
    test_phase_sync();
    test_negative_freq();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
